// File: rtl/apb_pkg.sv
// Shared encodings for the APB timer completer: bus FSM states, register offsets
// and control/status bit positions.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StWait  = 2'd1,
    StReady = 2'd2
  } apb_state_e;

  localparam logic [3:0] OffCtrl   = 4'h0;
  localparam logic [3:0] OffLoad   = 4'h4;
  localparam logic [3:0] OffValue  = 4'h8;
  localparam logic [3:0] OffStatus = 4'hC;

  localparam int unsigned CtrlEnBit    = 0;
  localparam int unsigned CtrlAutoBit  = 1;
  localparam int unsigned CtrlIrqEnBit = 2;
  localparam int unsigned CtrlWidth    = 3;

  localparam int unsigned StatusExpBit = 0;

endpackage

// File: rtl/apb_timer_core.sv
// Down-counting timer datapath: holds the current count and the sticky EXPIRED flag.
// A bus write to LOAD overrides any decrement or reload in the same cycle.
module apb_timer_core
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  enable,
  input  logic                  auto_reload,
  input  logic                  load_we,
  input  logic [DATA_WIDTH-1:0] load_val,
  input  logic                  clr_expired,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  expired,
  output logic                  en_clear
);

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic                  expired_q, expired_d;
  logic                  hit_zero;

  always_comb begin
    hit_zero = enable && (value_q == '0);
    value_d  = value_q;
    if (load_we) begin
      value_d = load_val;
    end else if (hit_zero) begin
      value_d = auto_reload ? load_val : '0;
    end else if (enable) begin
      value_d = value_q - DATA_WIDTH'(1);
    end
    // Expiry beats a simultaneous write-1-to-clear.
    expired_d = hit_zero ? 1'b1 : (clr_expired ? 1'b0 : expired_q);
    en_clear  = hit_zero && !auto_reload;
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      value_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      value_q   <= value_d;
      expired_q <= expired_d;
    end
  end

  assign value   = value_q;
  assign expired = expired_q;

endmodule

// File: rtl/apb_timer_slave.sv
// APB completer for a 32-bit down-counting timer: bus FSM with configurable wait
// states, CTRL/LOAD registers, read mux and error decode.
module apb_timer_slave
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [ADDR_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0] PWDATA,
  output logic [DATA_WIDTH-1:0] PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  output logic                  timer_irq
);

  localparam int unsigned WcW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  apb_state_e            state_q;
  logic [WcW-1:0]        wait_cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q;
  logic [DATA_WIDTH-1:0] wdata_q;

  logic [CtrlWidth-1:0]  ctrl_q;
  logic [DATA_WIDTH-1:0] load_q;

  logic [DATA_WIDTH-1:0] value;
  logic                  expired;
  logic                  en_clear;

  logic [ADDR_WIDTH-1:0] acc_addr;
  logic                  acc_write;
  logic                  acc_err;
  logic [DATA_WIDTH-1:0] acc_rdata;
  logic                  commit;
  logic                  load_we;

  // With zero wait states READY is entered straight from setup, so decode the live bus.
  always_comb begin
    acc_addr  = (state_q == StIdle) ? PADDR  : addr_q;
    acc_write = (state_q == StIdle) ? PWRITE : write_q;
    acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[ADDR_WIDTH-1:4] != '0) ||
                (acc_write && (acc_addr[3:0] == OffValue));
    acc_rdata = '0;
    if (!acc_err && !acc_write) begin
      case (acc_addr[3:0])
        OffCtrl:   acc_rdata = {{(DATA_WIDTH-CtrlWidth){1'b0}}, ctrl_q};
        OffLoad:   acc_rdata = load_q;
        OffValue:  acc_rdata = value;
        OffStatus: acc_rdata = {{(DATA_WIDTH-1){1'b0}}, expired};
        default:   acc_rdata = '0;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      wdata_q    <= '0;
      PREADY     <= 1'b0;
      PRDATA     <= '0;
      PSLVERR    <= 1'b0;
    end else begin
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      PSLVERR <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            if (WAIT_STATES == 0) begin
              state_q <= StReady;
              PREADY  <= 1'b1;
              PRDATA  <= acc_rdata;
              PSLVERR <= acc_err;
            end else begin
              state_q    <= StWait;
              wait_cnt_q <= WcW'(WAIT_STATES - 1);
            end
          end
        end
        StWait: begin
          if (!PSEL) begin
            state_q <= StIdle;
          end else if (wait_cnt_q == '0) begin
            state_q <= StReady;
            PREADY  <= 1'b1;
            PRDATA  <= acc_rdata;
            PSLVERR <= acc_err;
          end else begin
            wait_cnt_q <= wait_cnt_q - WcW'(1);
          end
        end
        StReady: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign commit  = (state_q == StReady) && write_q && !PSLVERR;
  assign load_we = commit && (addr_q[3:0] == OffLoad);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      ctrl_q <= '0;
      load_q <= '0;
    end else begin
      // A CTRL write overrides the one-shot self-disable.
      if (commit && (addr_q[3:0] == OffCtrl)) begin
        ctrl_q <= wdata_q[CtrlWidth-1:0];
      end else if (en_clear) begin
        ctrl_q[CtrlEnBit] <= 1'b0;
      end
      if (load_we) begin
        load_q <= wdata_q;
      end
    end
  end

  apb_timer_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_core (
    .PCLK       (PCLK),
    .PRESET     (PRESET),
    .enable     (ctrl_q[CtrlEnBit]),
    .auto_reload(ctrl_q[CtrlAutoBit]),
    .load_we    (load_we),
    .load_val   (load_we ? wdata_q : load_q),
    .clr_expired(commit && (addr_q[3:0] == OffStatus) && wdata_q[StatusExpBit]),
    .value      (value),
    .expired    (expired),
    .en_clear   (en_clear)
  );

  assign timer_irq = expired && ctrl_q[CtrlIrqEnBit];

endmodule
